// File: rtl/bf16_pkg.sv
// Shared constants and stage-1 record for the bfloat16 multiplier back end.
// Pure definitions: no logic, no latency.
// Backpressure: not applicable.
package bf16_pkg;

    localparam int BIAS     = 127;
    localparam int EXP_MAX  = 255;
    localparam logic [15:0] QNAN = 16'h7FC0;

    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_t;

    typedef struct packed {
        logic               sign;
        logic signed [9:0]  e;
        logic [6:0]         frac;
        logic               guard;
        logic               sticky;
        cls_t               cls;
    } s1_t;

endpackage

// File: rtl/bf16_round_pack.sv
// Round-to-nearest-even, exponent clamp and special-value mux for one result.
// Latency: combinational.
// Backpressure: none; the caller registers the outputs.
module bf16_round_pack
    import bf16_pkg::*;
(
    input  s1_t         s1,
    output logic [15:0] data,
    output logic [3:0]  flags
);

    localparam logic signed [9:0] E_MAX = 10'(EXP_MAX);

    logic              rnd_up;
    logic              carry;
    logic [6:0]        frac_r;
    logic signed [9:0] e_r;

    always_comb begin
        rnd_up          = s1.guard & (s1.sticky | s1.frac[0]);
        {carry, frac_r} = {1'b0, s1.frac} + {7'd0, rnd_up};
        e_r             = s1.e + $signed({9'd0, carry});

        data  = 16'h0000;
        flags = 4'h0;
        if (s1.cls == CLS_NAN) begin
            data                = QNAN;
            flags[FLAG_INVALID] = 1'b1;
        end else if (s1.cls == CLS_INF) begin
            data = {s1.sign, 8'hFF, 7'd0};
        end else if (s1.cls == CLS_ZERO) begin
            data = {s1.sign, 8'h00, 7'd0};
        end else if (e_r >= E_MAX) begin
            data                 = {s1.sign, 8'hFF, 7'd0};
            flags[FLAG_OVERFLOW] = 1'b1;
            flags[FLAG_INEXACT]  = 1'b1;
        end else if (e_r <= 10'sd0) begin
            // No subnormal outputs: anything below the normal range flushes.
            data                  = {s1.sign, 8'h00, 7'd0};
            flags[FLAG_UNDERFLOW] = 1'b1;
            flags[FLAG_INEXACT]   = 1'b1;
        end else begin
            data                = {s1.sign, e_r[7:0], frac_r};
            flags[FLAG_INEXACT] = s1.guard | s1.sticky;
        end
    end

endmodule

// File: rtl/bf16_mul_round_pack.sv
// bfloat16 multiplier back end: normalize, bias-correct, round, clamp, pack.
// Latency: 2 register stages (stage-1 record, then output register).
// Backpressure: valid/ready; in_ready = !v1 | !v2 | out_ready, no bubbles.
module bf16_mul_round_pack
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_prod,
    input  logic [7:0]  in_a_exp,
    input  logic [7:0]  in_b_exp,
    input  logic        in_a_frac_nz,
    input  logic        in_b_frac_nz,
    input  logic        in_sign,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [3:0]  out_flags
);

    logic        v1;
    logic        v2;
    logic        adv2;
    s1_t         s1_d;
    s1_t         s1_q;
    logic [15:0] rp_data;
    logic [3:0]  rp_flags;

    logic        norm;
    logic [9:0]  e_sum;
    logic        a_max, b_max, a_zero, b_zero;

    assign adv2      = !v2 | out_ready;
    assign in_ready  = !v1 | adv2;
    assign out_valid = v2;

    always_comb begin
        norm   = in_prod[15];
        // 10-bit wrap gives the two's-complement value in -127..384.
        e_sum  = {2'b00, in_a_exp} + {2'b00, in_b_exp} + {9'd0, norm} - 10'(BIAS);
        a_max  = (in_a_exp == 8'(EXP_MAX));
        b_max  = (in_b_exp == 8'(EXP_MAX));
        a_zero = (in_a_exp == 8'd0);
        b_zero = (in_b_exp == 8'd0);

        s1_d.sign = in_sign;
        s1_d.e    = $signed(e_sum);
        if (norm) begin
            s1_d.frac   = in_prod[14:8];
            s1_d.guard  = in_prod[7];
            s1_d.sticky = |in_prod[6:0];
        end else begin
            s1_d.frac   = in_prod[13:7];
            s1_d.guard  = in_prod[6];
            s1_d.sticky = |in_prod[5:0];
        end

        if ((a_max & in_a_frac_nz) | (b_max & in_b_frac_nz) |
            (a_max & b_zero) | (b_max & a_zero))
            s1_d.cls = CLS_NAN;
        else if (a_max | b_max)
            s1_d.cls = CLS_INF;
        else if (a_zero | b_zero)
            s1_d.cls = CLS_ZERO;
        else
            s1_d.cls = CLS_NORM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            v1 <= 1'b0;
        else if (in_ready)
            v1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid & in_ready)
            s1_q <= s1_d;
    end

    bf16_round_pack u_round_pack (
        .s1    (s1_q),
        .data  (rp_data),
        .flags (rp_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            out_data  <= 16'h0000;
            out_flags <= 4'h0;
        end else if (adv2) begin
            v2 <= v1;
            if (v1) begin
                out_data  <= rp_data;
                out_flags <= rp_flags;
            end
        end
    end

endmodule

// File: tb/tb_bf16_mul_round_pack.sv
// Directed self-checking bench for bf16_mul_round_pack.
module tb_bf16_mul_round_pack;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_prod;
    logic [7:0]  in_a_exp;
    logic [7:0]  in_b_exp;
    logic        in_a_frac_nz;
    logic        in_b_frac_nz;
    logic        in_sign;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_flags;

    bf16_mul_round_pack dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_prod      (in_prod),
        .in_a_exp     (in_a_exp),
        .in_b_exp     (in_b_exp),
        .in_a_frac_nz (in_a_frac_nz),
        .in_b_frac_nz (in_b_frac_nz),
        .in_sign      (in_sign),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_flags    (out_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] prod;
        logic [7:0]  ae;
        logic [7:0]  be;
        logic        anz;
        logic        bnz;
        logic        sign;
        logic [15:0] exp_d;
        logic [3:0]  exp_f;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int i);
        in_valid     = 1'b1;
        in_prod      = vecs[i].prod;
        in_a_exp     = vecs[i].ae;
        in_b_exp     = vecs[i].be;
        in_a_frac_nz = vecs[i].anz;
        in_b_frac_nz = vecs[i].bnz;
        in_sign      = vecs[i].sign;
    endtask

    // One isolated transaction: check latency, data, flags and drain.
    task automatic run_one(input int i);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(i);
        @(negedge clk);
        chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_lat1_valid", i), 32'(out_valid), 32'd0);
        @(negedge clk);
        chk($sformatf("v%0d_lat2_valid", i), 32'(out_valid), 32'd1);
        chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].exp_d));
        chk($sformatf("v%0d_flags", i), 32'(out_flags), 32'(vecs[i].exp_f));
        @(negedge clk);
        chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    endtask

    vec_t exp_q[$];

    initial begin
        int idx;
        int got;
        int cyc;
        vecs[0]  = '{16'h4000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h3F80, 4'h0};
        vecs[1]  = '{16'h9000, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h4010, 4'h0};
        vecs[2]  = '{16'h60C0, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h3FC2, 4'h1};
        vecs[3]  = '{16'h6240, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h3FC4, 4'h1};
        vecs[4]  = '{16'h4000, 8'd254, 8'd254, 1'b0, 1'b0, 1'b0, 16'h7F80, 4'h5};
        vecs[5]  = '{16'h4000, 8'd1,   8'd1,   1'b0, 1'b0, 1'b0, 16'h0000, 4'h3};
        vecs[6]  = '{16'h4000, 8'd255, 8'd0,   1'b0, 1'b0, 1'b0, 16'h7FC0, 4'h8};
        vecs[7]  = '{16'h4000, 8'd255, 8'd127, 1'b1, 1'b0, 1'b0, 16'h7FC0, 4'h8};
        vecs[8]  = '{16'h4000, 8'd0,   8'd127, 1'b0, 1'b0, 1'b1, 16'h8000, 4'h0};
        vecs[9]  = '{16'h4000, 8'd255, 8'd127, 1'b0, 1'b0, 1'b1, 16'hFF80, 4'h0};
        vecs[10] = '{16'h7FC0, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h4000, 4'h1};
        vecs[11] = '{16'h4000, 8'd191, 8'd191, 1'b0, 1'b0, 1'b0, 16'h7F80, 4'h5};
        vecs[12] = '{16'h4000, 8'd64,  8'd63,  1'b0, 1'b0, 1'b0, 16'h0000, 4'h3};
        vecs[13] = '{16'h4000, 8'd64,  8'd64,  1'b0, 1'b0, 1'b0, 16'h0080, 4'h0};
        vecs[14] = '{16'h7FC0, 8'd191, 8'd190, 1'b0, 1'b0, 1'b0, 16'h7F80, 4'h5};
        vecs[15] = '{16'h8001, 8'd127, 8'd127, 1'b0, 1'b0, 1'b0, 16'h4000, 4'h1};

        rst_n        = 1'b0;
        in_valid     = 1'b0;
        in_prod      = 16'h0;
        in_a_exp     = 8'h0;
        in_b_exp     = 8'h0;
        in_a_frac_nz = 1'b0;
        in_b_frac_nz = 1'b0;
        in_sign      = 1'b0;
        out_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_flags", 32'(out_flags), 32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < NV; i++) run_one(i);

        // Back-to-back stream with random backpressure; the queue front is
        // the required output whenever out_valid is high, stalled or not.
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 300) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
            if (idx < 8) drive(idx);
            else in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("stream_spurious", 32'(out_valid), 32'd0);
                end else begin
                    chk($sformatf("stream%0d_data", got), 32'(out_data), 32'(exp_q[0].exp_d));
                    chk($sformatf("stream%0d_flags", got), 32'(out_flags), 32'(exp_q[0].exp_f));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        got++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(vecs[idx]);
                idx++;
            end
            cyc++;
        end
        chk("stream_count", 32'(got), 32'd8);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("stream_no_dup", 32'(out_valid), 32'd0);

        // Fill both stages under backpressure, then reset mid-flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(1);
        @(posedge clk); #1;
        drive(2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'h0);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("postrst_valid%0d", k), 32'(out_valid), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
